// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter
//   Two-requester burst fetch engine in front of a synchronous sprite ROM.
//   Round-robin arbitration accepts one burst at a time. The first beat is
//   issued in the acceptance cycle, and the remaining beats follow one per
//   cycle. The ROM answers one cycle after each beat, and that answer is
//   steered back to the owning requester.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   req0/1              burst request, held until granted
//   base0/1, len0/1     burst start address and length (0 -> 1, >16 -> 16)
//   gnt0/1              one-cycle acceptance pulse
//   rom_addr, rom_data  synchronous ROM address (0 when idle/oob) and data
//   rdata               returned pixel (0 for out-of-range beats)
//   rvalid0/1           rdata valid for requester 0/1
//   rlast, oob          last beat of burst / beat was out of ROM range
//   busy                a multi-beat burst is in progress
module sprite_fetch_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24,
  parameter int ROM_DEPTH = 1140
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [4:0]        len0,
  input  logic [4:0]        len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rlast,
  output logic              oob,
  output logic              busy
);

  localparam logic [0:0]        S_IDLE  = 1'b0;
  localparam logic [0:0]        S_BURST = 1'b1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(ROM_DEPTH);

  // Clamp a requested length into the supported 1..16 range.
  function automatic logic [4:0] eff_len(input logic [4:0] l);
    if (l == 5'd0)  return 5'd1;
    if (l > 5'd16)  return 5'd16;
    return l;
  endfunction

  logic [0:0]        state_q, state_d;
  logic              ptr_q, ptr_d;      // requester granted most recently
  logic              owner_q, owner_d;  // owner of the burst in progress
  logic [4:0]        rem_q, rem_d;      // beats still to issue in BURST
  logic [ADDR_W-1:0] cur_q, cur_d;      // next beat address in BURST

  logic              vld0_q, vld0_d;
  logic              vld1_q, vld1_d;
  logic              last_q, last_d;
  logic              oob_q, oob_d;

  logic              win;
  logic [ADDR_W-1:0] win_base;
  logic [4:0]        win_len;
  logic              issue;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;
  logic              beat_owner;
  logic              beat_oob;

  // Issue stage: arbitration, beat generation and ROM addressing
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    rem_d      = rem_q;
    cur_d      = cur_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    issue      = 1'b0;
    beat_addr  = '0;
    beat_last  = 1'b0;
    beat_owner = owner_q;

    // On a tie the requester not granted last wins; otherwise whoever asks.
    win      = (req0 && req1) ? ~ptr_q : req1;
    win_base = win ? base1 : base0;
    win_len  = eff_len(win ? len1 : len0);

    // While Reset is high nothing is issued or granted.
    if (!Reset) begin
      if (state_q == S_BURST) begin
        issue     = 1'b1;
        beat_addr = cur_q;
        beat_last = (rem_q == 5'd1);
        cur_d     = cur_q + ADDR_W'(1);
        rem_d     = rem_q - 5'd1;
        if (rem_q == 5'd1) state_d = S_IDLE;
      end else if (req0 || req1) begin
        issue      = 1'b1;
        beat_addr  = win_base;
        beat_owner = win;
        beat_last  = (win_len == 5'd1);
        gnt0       = ~win;
        gnt1       = win;
        ptr_d      = win;
        owner_d    = win;
        if (win_len != 5'd1) begin
          state_d = S_BURST;
          rem_d   = win_len - 5'd1;
          cur_d   = win_base + ADDR_W'(1);
        end
      end
    end

    // Out-of-range beats still count toward the burst but read address 0.
    beat_oob = (beat_addr >= DEPTH_A);
    rom_addr = (issue && !beat_oob) ? beat_addr : '0;

    vld0_d = issue && !beat_owner;
    vld1_d = issue && beat_owner;
    last_d = issue && beat_last;
    oob_d  = issue && beat_oob;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b1;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      last_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      last_q  <= last_d;
      oob_q   <= oob_d;
    end
  end

  // Burst bookkeeping is only consulted in BURST, which is always entered
  // with freshly loaded values, so it needs no reset.
  always_ff @(posedge Clk) begin
    owner_q <= owner_d;
    rem_q   <= rem_d;
    cur_q   <= cur_d;
  end

  // Return stage: ROM data arrives one cycle after its beat
  assign rvalid0 = vld0_q;
  assign rvalid1 = vld1_q;
  assign rlast   = last_q;
  assign oob     = oob_q;
  assign rdata   = ((vld0_q || vld1_q) && !oob_q) ? rom_data : '0;
  assign busy    = (state_q == S_BURST);

endmodule
